// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Computes a + ~b + 1 through one full adder and a registered carry.

// One-bit full adder used as the serial arithmetic element.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic C_in,
   output logic S,
   output logic C_out
);

   assign S     = A ^ B ^ C_in;
   assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

module serial_subtractor #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // Bit 0 is busy and bit 1 is done, so both outputs come straight off flops.
   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] SHIFT = 2'b01;
   localparam logic [1:0] DONE  = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] nb_sr_q, nb_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             carry_q, carry_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic fa_s;
   logic fa_c;

   full_adder u_fa (
      .A     (a_sr_q[0]),
      .B     (nb_sr_q[0]),
      .C_in  (carry_q),
      .S     (fa_s),
      .C_out (fa_c)
   );

   // Next-state: accept operands when idle/done, shift one bit per cycle.
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      nb_sr_d  = nb_sr_q;
      res_sr_d = res_sr_q;
      diff_d   = diff_q;
      carry_d  = carry_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = SHIFT;
               a_sr_d  = a;
               nb_sr_d = ~b;
               carry_d = 1'b1;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            nb_sr_d  = nb_sr_q >> 1;
            res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
            carry_d  = fa_c;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d  = DONE;
               diff_d   = {fa_s, res_sr_q[WIDTH-1:1]};
               borrow_d = ~fa_c;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         nb_sr_q  <= '0;
         res_sr_q <= '0;
         diff_q   <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         nb_sr_q  <= nb_sr_d;
         res_sr_q <= res_sr_d;
         diff_q   <= diff_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy   = state_q[0];
   assign done   = state_q[1];
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes DIFF = A − B, LSB first, one bit per clock.
- Uses a single full_adder instance (ports A, B, C_in, S, C_out) with a registered carry, implementing A + ~B + 1.
- It is the sequential inverse-operation counterpart to the combinational ripple-carry adder chain; it is the subtract path of the arithmetic datapath.
- It has a start/busy/done handshake so a controller can issue back-to-back operations.

Parameters:
- WIDTH, 3, operand and result width in bits (≥2)

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- start  input   1      request; sampled only when the block is idle or done
- a      input   WIDTH  minuend, captured on the accepting edge
- b      input   WIDTH  subtrahend, captured on the accepting edge
- busy   output  1      high while bits are being processed
- done   output  1      one-cycle pulse: diff/borrow are valid
- diff   output  WIDTH  (a − b) mod 2^WIDTH
- borrow output  1      1 when a < b (unsigned), i.e. inverted final carry

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, diff=0, borrow=0; internal shift registers, carry and bit counter cleared. Reset has priority over everything, including mid-operation; a partial result is discarded and no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → on that edge capture a_sr=a, nb_sr=~b, carry=1, cnt=0; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, each edge:
  - s = a_sr[0] ^ nb_sr[0] ^ carry (the full_adder S output); carry ← full_adder C_out.
  - a_sr and nb_sr shift right by 1.
  - res_sr shifts right with s entering at bit WIDTH-1.
  - cnt increments.
  - On the edge where cnt reaches WIDTH-1 (the WIDTH-th bit): go to DONE; load diff with the final res_sr and borrow = ~C_out.
- DONE: lasts exactly one cycle.
  - start=1 → accepted exactly as in IDLE; go to SHIFT.
  - start=0 → go to IDLE.
- busy = 1 exactly in SHIFT. done = 1 exactly in DONE. Both are registered outputs, glitch-free.
- Latency: for start accepted at edge k, busy is high for cycles k+1 … k+WIDTH, and done is high for the single cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles with start held high.
- start while busy: ignored; operands are not re-captured.
- a and b are don't-care except at the accepting edge; changes mid-operation must not affect the result.
- diff and borrow hold their last value until the next completion or reset. They do not change at accept or during SHIFT.
- Arithmetic is purely modulo 2^WIDTH; there is no signed overflow output.
- Carry is initialised to 1 at every accept, so results are not affected by the previous operation's carry.

Test Plan (WIDTH=3):
- 5 − 3: start with a=3'b101, b=3'b011 → busy high 3 cycles, then done pulse for 1 cycle; diff=3'b010, borrow=0.
- 3 − 5 and 0 − 1: → diff=3'b110, borrow=1; then diff=3'b111, borrow=1. Extremes 0−0 and 7−7 → diff=0, borrow=0; 7−0 → diff=7, borrow=0.
- Exhaustive sweep of all 64 (a,b) pairs, back-to-back with start held high → each done cycle shows diff=(a−b)&7 and borrow=(a<b); spacing between done pulses is exactly 4 cycles.
- Operand stability: start with a=6, b=2, then drive a=1, b=7 on the next cycle and pulse start again while busy → single done only, with diff=4, borrow=0; the second start produces no extra done.
- Reset mid-operation: start a=2, b=5, assert rst in the 2nd busy cycle → next cycle busy=0, done=0, diff=0, borrow=0; no done afterwards. A new start a=4, b=1 then yields diff=3, borrow=0 after the normal latency.
- Hold check: after a completion with diff=2, leave start low for 10 cycles → diff/borrow stable, busy=0, done=0 throughout.
